// File: rtl/filter_pkg.sv
// filter_pkg: shared kernel/FSM types, RGB565 channel layout and per-channel
// 3x3 convolution with clamp, used by conv3x3_filter and its line buffer.
package filter_pkg;
    typedef enum logic [1:0] {IDENTITY, GAUSSIAN, SHARPEN, EDGE} kernel_t;
    typedef enum logic {WAIT_FRAME, RUN} state_t;
    localparam int ACC_W = 12;
    localparam int LATENCY = 3;
    localparam int R_OFF = 11;
    localparam int R_W = 5;
    localparam int G_OFF = 5;
    localparam int G_W = 6;
    localparam int B_OFF = 0;
    localparam int B_W = 5;
    typedef struct packed {
        logic [5:0] val;
        logic       sat;
    } chan_t;
    function automatic logic signed [ACC_W-1:0] ext(logic [5:0] x);
        return $signed(ACC_W'(x));
    endfunction
    // w is row-major top-left first; m is the channel's maximum code
    function automatic chan_t conv_chan(kernel_t k, logic [8:0][5:0] w, logic [5:0] m);
        logic signed [ACC_W-1:0] c, n, d, a, mx;
        chan_t r;
        c  = ext(w[4]);
        n  = ext(w[1]) + ext(w[3]) + ext(w[5]) + ext(w[7]);
        d  = ext(w[0]) + ext(w[2]) + ext(w[6]) + ext(w[8]);
        mx = ext(m);
        a  = k == IDENTITY ? c :
             k == GAUSSIAN ? (d + (n <<< 1) + (c <<< 2)) >>> 4 :
             k == SHARPEN  ? (c <<< 2) + c - n :
                             (c <<< 3) - n - d;
        r.sat = a[ACC_W-1] || a > mx;
        r.val = a[ACC_W-1] ? 6'd0 : a > mx ? m : a[5:0];
        return r;
    endfunction
endpackage

// File: rtl/conv3x3_filter_if.sv
// conv3x3_filter_if: RGB565 pixel stream with raster coordinate tagging.
interface conv3x3_filter_if #(
    parameter int HCOUNT_W = 11,
    parameter int VCOUNT_W = 10
);
    logic                data_valid;
    logic [15:0]         pixel_data;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    modport master (output data_valid, pixel_data, hcount, vcount);
    modport slave  (input  data_valid, pixel_data, hcount, vcount);
endinterface

// File: rtl/window_line_buffer.sv
// window_line_buffer: two line memories feeding a 3x3 shift window (S1 read, S2 shift),
// with the valid/coordinate tags delayed alongside.
module window_line_buffer #(
    parameter int H_RES    = 320,
    parameter int HCOUNT_W = 11,
    parameter int VCOUNT_W = 10
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    conv3x3_filter_if.slave      in_if,
    output logic                 valid_o,
    output logic [HCOUNT_W-1:0]  hcount_o,
    output logic [VCOUNT_W-1:0]  vcount_o,
    output logic [8:0][15:0]     window_o
);
    localparam int AW = $clog2(H_RES);
    logic [15:0]         line0_q [H_RES];
    logic [15:0]         line1_q [H_RES];
    logic [AW-1:0]       addr;
    logic [2:0][15:0]    col_q;
    logic [2:0][2:0][15:0] win_q;
    logic                vld1_q, vld2_q;
    logic [HCOUNT_W-1:0] hc1_q, hc2_q;
    logic [VCOUNT_W-1:0] vc1_q, vc2_q;
    assign addr = in_if.hcount[AW-1:0];
    // line0 holds row v-1, line1 row v-2; reads see pre-write contents
    always_ff @(posedge clk_in) begin
        if (in_if.data_valid) begin
            line0_q[addr] <= in_if.pixel_data;
            line1_q[addr] <= line0_q[addr];
        end
        col_q <= {in_if.pixel_data, line0_q[addr], line1_q[addr]};
        hc1_q <= in_if.hcount;
        vc1_q <= in_if.vcount;
        if (vld1_q) win_q <= {col_q, win_q[2:1]};
        hc2_q <= hc1_q;
        vc2_q <= vc1_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            vld1_q <= in_if.data_valid;
            vld2_q <= vld1_q;
        end
    end
    for (genvar r = 0; r < 3; r++) begin : g_r
        for (genvar c = 0; c < 3; c++) begin : g_c
            assign window_o[r*3+c] = win_q[c][r];
        end
    end
    assign valid_o  = vld2_q;
    assign hcount_o = hc2_q;
    assign vcount_o = vc2_q;
endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: run-time selectable 3x3 RGB565 kernel filter, latency 3, tags carried through.
// Optional clamp counter on sat_count_out when CONV_SAT_COUNT_EN is defined.
module conv3x3_filter
    import filter_pkg::*;
#(
    parameter int         H_RES     = 320,
    parameter int         HCOUNT_W  = 11,
    parameter int         VCOUNT_W  = 10,
    parameter logic [1:0] DEFAULT_K = 2'd0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [1:0]      k_select_in,
`ifdef CONV_SAT_COUNT_EN
    output logic [15:0]     sat_count_out,
`endif
    conv3x3_filter_if.slave  in_if,
    conv3x3_filter_if.master out_if
);
    logic                s2_vld;
    logic [HCOUNT_W-1:0] s2_hc, hc_q;
    logic [VCOUNT_W-1:0] s2_vc, vc_q;
    logic [8:0][15:0]    win;
    logic [8:0][5:0]     wr, wg, wb;
    chan_t               cr, cg, cb;
    state_t              state_q;
    kernel_t             kernel_q, k1_q, k2_q;
    logic                run1_q, run2_q, sof, zero, dv_q;
    logic [15:0]         px_d, px_q;
    window_line_buffer #(.H_RES(H_RES), .HCOUNT_W(HCOUNT_W), .VCOUNT_W(VCOUNT_W)) u_wlb (
        .clk_in(clk_in), .rst_in(rst_in), .in_if(in_if),
        .valid_o(s2_vld), .hcount_o(s2_hc), .vcount_o(s2_vc), .window_o(win)
    );
    assign sof = in_if.data_valid && in_if.hcount == '0 && in_if.vcount == '0;
    // kernel and run flag travel with each pixel so frame boundaries stay exact
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= WAIT_FRAME;
            kernel_q <= kernel_t'(DEFAULT_K);
            k1_q     <= kernel_t'(DEFAULT_K);
            k2_q     <= kernel_t'(DEFAULT_K);
            run1_q   <= 1'b0;
            run2_q   <= 1'b0;
        end else begin
            if (sof) begin
                state_q  <= RUN;
                kernel_q <= kernel_t'(k_select_in);
            end
            k1_q   <= sof ? kernel_t'(k_select_in) : kernel_q;
            run1_q <= sof || state_q == RUN;
            k2_q   <= k1_q;
            run2_q <= run1_q;
        end
    end
    always_comb begin
        wr = '0;
        wg = '0;
        wb = '0;
        for (int i = 0; i < 9; i++) begin
            wr[i] = 6'(win[i][R_OFF +: R_W]);
            wg[i] = 6'(win[i][G_OFF +: G_W]);
            wb[i] = 6'(win[i][B_OFF +: B_W]);
        end
    end
    assign cr   = conv_chan(k2_q, wr, 6'd31);
    assign cg   = conv_chan(k2_q, wg, 6'd63);
    assign cb   = conv_chan(k2_q, wb, 6'd31);
    assign zero = !run2_q || s2_hc < HCOUNT_W'(2) || s2_vc < VCOUNT_W'(2);
    assign px_d = zero ? 16'h0000 : {cr.val[4:0], cg.val, cb.val[4:0]};
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dv_q <= 1'b0;
            px_q <= '0;
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            dv_q <= s2_vld;
            px_q <= px_d;
            hc_q <= s2_hc;
            vc_q <= s2_vc;
        end
    end
    assign out_if.data_valid = dv_q;
    assign out_if.pixel_data = px_q;
    assign out_if.hcount     = hc_q;
    assign out_if.vcount     = vc_q;
    logic unused_bits;
`ifdef CONV_SAT_COUNT_EN
    logic [15:0] cnt_q, cnt_d, sat_q;
    logic [1:0]  inc;
    always_comb begin
        inc   = (s2_vld && !zero) ? 2'(cr.sat) + 2'(cg.sat) + 2'(cb.sat) : 2'd0;
        cnt_d = cnt_q > 16'hFFFF - 16'(inc) ? 16'hFFFF : cnt_q + 16'(inc);
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            sat_q <= '0;
        end else if (sof) begin
            sat_q <= cnt_d;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign sat_count_out = sat_q;
    assign unused_bits   = ^{cr.val[5], cb.val[5]};
`else
    assign unused_bits   = ^{cr.val[5], cb.val[5], cr.sat, cg.sat, cb.sat};
`endif
endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: directed frames against a weight-table reference model via a timed scoreboard.
module tb_conv3x3_filter;
    localparam int H = 96;
    typedef struct {
        logic [15:0] px;
        int          h;
        int          v;
        int          due;
        int          fid;
    } exp_t;
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [1:0] k_select_in = 2'd0;
`ifdef CONV_SAT_COUNT_EN
    logic [15:0] sat_count_out;
`endif
    conv3x3_filter_if #(.HCOUNT_W(11), .VCOUNT_W(10)) in_if ();
    conv3x3_filter_if #(.HCOUNT_W(11), .VCOUNT_W(10)) out_if ();
    conv3x3_filter #(.H_RES(H), .HCOUNT_W(11), .VCOUNT_W(10), .DEFAULT_K(2'd0)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .k_select_in(k_select_in),
`ifdef CONV_SAT_COUNT_EN
        .sat_count_out(sat_count_out),
`endif
        .in_if(in_if),
        .out_if(out_if)
    );
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int m_run = 0;
    int m_k = 0;
    int fid = 0;
    exp_t q[$];
    exp_t me;
    int seen [int];
    logic [15:0] img [128][H];
    int wgt [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                       '{1, 2, 1, 2, 4, 2, 1, 2, 1},
                       '{0, -1, 0, -1, 5, -1, 0, -1, 0},
                       '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};
    int offs [3] = '{11, 5, 0};
    int wids [3] = '{5, 6, 5};

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int key(input int f, input int h, input int v);
        return f * (1 << 20) + v * 1024 + h;
    endfunction

    function automatic int get(input int f, input int h, input int v);
        return seen.exists(key(f, h, v)) ? seen[key(f, h, v)] : -1;
    endfunction

    function automatic logic [15:0] model(input int h, input int v);
        int res, s, mx;
        if (m_run == 0 || h < 2 || v < 2) return 16'h0000;
        res = 0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            mx = (1 << wids[ch]) - 1;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += wgt[m_k][r*3+c] * ((int'(img[v-2+r][h-2+c]) >> offs[ch]) & mx);
            if (m_k == 1) s = s / 16;
            if (s < 0) s = 0;
            if (s > mx) s = mx;
            res = res | (s << offs[ch]);
        end
        return 16'(res);
    endfunction

    task automatic step(input logic vld, input logic [15:0] p, input int h, input int v,
                        input logic [1:0] k, input logic r);
        exp_t e;
        in_if.data_valid = vld;
        in_if.pixel_data = p;
        in_if.hcount = 11'(h);
        in_if.vcount = 10'(v);
        k_select_in = k;
        rst_in = r;
        if (vld) img[v][h] = p;
        if (r) begin
            m_run = 0;
            m_k = 0;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else if (vld) begin
            if (h == 0 && v == 0) begin
                m_run = 1;
                m_k = int'(k);
                fid++;
            end
            e.px = model(h, v);
            e.h = h;
            e.v = v;
            e.due = cyc + 3;
            e.fid = fid;
            q.push_back(e);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        in_if.data_valid = 1'b0;
    endtask

    // mode 0 ramp (pixel=h), 1 flat 0x8410, 2 single white dot at (10,10)
    task automatic frame(input int mode, input int rows, input logic [1:0] k, input int gap,
                         input int sw_v, input int sw_h, input int rst_v, input int rst_h);
        logic [1:0]  kk;
        logic [15:0] p;
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h < H; h++) begin
                kk = (sw_v >= 0 && (v > sw_v || (v == sw_v && h >= sw_h))) ? 2'd3 : k;
                while (int'($urandom_range(99)) < gap) step(1'b0, 16'h0, h, v, kk, 1'b0);
                p = mode == 0 ? 16'(h) : mode == 1 ? 16'h8410 : (h == 10 && v == 10) ? 16'hFFFF : 16'h0000;
                step(1'b1, p, h, v, kk, v == rst_v && h == rst_h);
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (out_if.data_valid === 1'b1) begin
            chk("expected_pending", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                me = q.pop_front();
                chk($sformatf("pixel@%0d,%0d", me.h, me.v), int'(out_if.pixel_data), int'(me.px));
                chk("hcount", int'(out_if.hcount), me.h);
                chk("vcount", int'(out_if.vcount), me.v);
                chk("latency", cyc, me.due);
                seen[key(me.fid, me.h, me.v)] = int'(out_if.pixel_data);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            chk("valid_on_time", int'(out_if.data_valid), 1);
            void'(q.pop_front());
        end
    end

    initial begin
        int diff;
        in_if.data_valid = 1'b0;
        in_if.pixel_data = 16'h0;
        in_if.hcount = '0;
        in_if.vcount = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", int'(out_if.data_valid), 0);
        chk("rst_pixel", int'(out_if.pixel_data), 0);
        chk("rst_hcount", int'(out_if.hcount), 0);
        chk("rst_vcount", int'(out_if.vcount), 0);
`ifdef CONV_SAT_COUNT_EN
        chk("rst_sat", int'(sat_count_out), 0);
`endif
        rst_in = 1'b0;
        frame(0, 6, 2'd0, 0, -1, 0, -1, 0);
        frame(0, 6, 2'd0, 30, -1, 0, -1, 0);
        frame(1, 5, 2'd1, 0, -1, 0, -1, 0);
        frame(1, 5, 2'd2, 0, -1, 0, -1, 0);
        frame(1, 5, 2'd3, 0, -1, 0, -1, 0);
        chk("ramp_id_5_3", get(1, 5, 3), 4);
        chk("ramp_col_border", get(1, 1, 3), 0);
        chk("ramp_row_border", get(1, 5, 1), 0);
        chk("gap_ramp_40_4", get(2, 40, 4), 39);
        diff = 0;
        for (int v = 0; v < 6; v++)
            for (int h = 0; h < H; h++)
                if (get(1, h, v) < 0 || get(2, h, v) != get(1, h, v)) diff++;
        chk("gap_vs_nogap_diffs", diff, 0);
        frame(2, 14, 2'd3, 0, -1, 0, -1, 0);
        chk("flat_gauss", get(3, 50, 3), 16'h8410);
        chk("flat_sharpen", get(4, 50, 3), 16'h8410);
        chk("flat_edge", get(5, 50, 3), 0);
        frame(0, 102, 2'd0, 0, 100, 50, -1, 0);
        chk("dot_centre", get(6, 11, 11), 16'hFFFF);
        chk("dot_left", get(6, 10, 11), 0);
        chk("dot_diag", get(6, 12, 12), 0);
        chk("dot_ul", get(6, 10, 10), 0);
`ifdef CONV_SAT_COUNT_EN
        chk("sat_count_dot", int'(sat_count_out), 27);
`endif
        frame(0, 5, 2'd3, 0, -1, 0, -1, 0);
        chk("pre_switch_id", get(7, 40, 100), 39);
        chk("post_switch_still_id", get(7, 60, 101), 59);
        chk("next_frame_edge", get(8, 20, 3), 0);
        frame(0, 122, 2'd0, 0, -1, 0, 120, 80);
        frame(0, 5, 2'd0, 0, -1, 0, -1, 0);
        repeat (6) step(1'b0, 16'h0, 0, 0, 2'd0, 1'b0);
        chk("drain_empty", q.size(), 0);
        chk("before_reset_id", get(9, 40, 120), 39);
        chk("reset_dropped", get(9, 80, 120), -1);
        chk("after_reset_zero", get(9, 85, 120), 0);
        chk("wait_row_zero", get(9, 50, 121), 0);
        chk("resume_id", get(10, 5, 3), 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
